// File: rtl/latch_gate_sequencer.sv
// Round-robin write sequencer for a transparent-latch bank: opens the gate only inside a
// SETUP/OPEN/HOLD window and owns the bank's SET/RST init so GE never overlaps them.
module latch_gate_sequencer #(
    parameter int   NREQ      = 4,
    parameter int   DW        = 8,
    parameter int   SETUP_CYC = 1,
    parameter int   GATE_CYC  = 2,
    parameter int   HOLD_CYC  = 1,
    parameter int   INIT_CYC  = 2,
    parameter logic INIT_VAL  = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*DW-1:0] i_wdata,
    input  logic               i_soft_init,
    output logic [NREQ-1:0]    o_gnt,
    output logic               o_done,
    output logic               o_busy,
    output logic [DW-1:0]      o_lat_i,
    output logic               o_lat_ge,
    output logic               o_lat_rst,
    output logic               o_lat_set
);

    localparam int MAXA = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
    localparam int MAXB = (HOLD_CYC > INIT_CYC) ? HOLD_CYC : INIT_CYC;
    localparam int MAXC = (MAXA > MAXB) ? MAXA : MAXB;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_HOLD,
        S_FIN
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic              r_done;
    logic              r_busy;
    logic [DW-1:0]     r_lat_i;
    logic              r_lat_ge;
    logic              r_lat_rst;
    logic              r_lat_set;

    logic              w_found;
    logic [PW-1:0]     w_winner;
    logic [NREQ-1:0]   w_onehot;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[(int'(r_ptr) + 1 + i) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = PW'((int'(r_ptr) + 1 + i) % NREQ);
            end
        end
    end

    assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_INIT;
            r_cnt     <= CW'(INIT_CYC - 1);
            r_ptr     <= PW'(NREQ - 1);
            r_gnt     <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_lat_i   <= '0;
            r_lat_ge  <= 1'b0;
            r_lat_rst <= ~INIT_VAL;
            r_lat_set <= INIT_VAL;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_cnt == '0) begin
                        r_lat_rst <= 1'b0;
                        r_lat_set <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_soft_init) begin
                        r_lat_rst <= ~INIT_VAL;
                        r_lat_set <= INIT_VAL;
                        r_cnt     <= CW'(INIT_CYC - 1);
                        r_busy    <= 1'b1;
                        r_state   <= S_INIT;
                    end else if (w_found) begin
                        r_gnt   <= w_onehot;
                        r_lat_i <= i_wdata[int'(w_winner)*DW +: DW];
                        r_ptr   <= w_winner;
                        r_cnt   <= CW'(SETUP_CYC - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_lat_ge <= 1'b1;
                        r_cnt    <= CW'(GATE_CYC - 1);
                        r_state  <= S_OPEN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_OPEN: begin
                    if (r_cnt == '0) begin
                        r_lat_ge <= 1'b0;
                        r_cnt    <= CW'(HOLD_CYC - 1);
                        r_state  <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_lat_ge  <= 1'b0;
                    r_gnt     <= '0;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b1;
                    r_lat_rst <= ~INIT_VAL;
                    r_lat_set <= INIT_VAL;
                    r_cnt     <= CW'(INIT_CYC - 1);
                    r_state   <= S_INIT;
                end
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_done    = r_done;
    assign o_busy    = r_busy;
    assign o_lat_i   = r_lat_i;
    assign o_lat_ge  = r_lat_ge;
    assign o_lat_rst = r_lat_rst;
    assign o_lat_set = r_lat_set;

endmodule

// File: tb/tb_latch_gate_sequencer.sv
// Directed bench for latch_gate_sequencer with default parameters; expected values are
// hand-derived from the grant-edge timing (GE k+1..k+3, DONE k+4, idle k+5).
module tb_latch_gate_sequencer;

    logic        clk;
    logic        rstN;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        softInit;
    logic [3:0]  gnt;
    logic        done;
    logic        busy;
    logic [7:0]  latI;
    logic        latGe;
    logic        latRst;
    logic        latSet;

    int checks   = 0;
    int failures = 0;
    int doneCount;

    latch_gate_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_req       (req),
        .i_wdata     (wdata),
        .i_soft_init (softInit),
        .o_gnt       (gnt),
        .o_done      (done),
        .o_busy      (busy),
        .o_lat_i     (latI),
        .o_lat_ge    (latGe),
        .o_lat_rst   (latRst),
        .o_lat_set   (latSet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic s);
        req      = r;
        wdata    = d;
        softInit = s;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(4'b0000, 32'h0, 1'b0);
        repeat (3) @(negedge clk);

        checkOutput("rst_lat_rst", {31'b0, latRst}, 32'd1);
        checkOutput("rst_lat_set", {31'b0, latSet}, 32'd0);
        checkOutput("rst_ge", {31'b0, latGe}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd1);
        checkOutput("rst_gnt", {28'b0, gnt}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_lat_i", {24'b0, latI}, 32'd0);

        rstN = 1'b1;
        tick();
        checkOutput("init1_lat_rst", {31'b0, latRst}, 32'd1);
        checkOutput("init1_busy", {31'b0, busy}, 32'd1);
        tick();
        checkOutput("init2_lat_rst", {31'b0, latRst}, 32'd0);
        checkOutput("init2_busy", {31'b0, busy}, 32'd0);

        // single write from requester 2
        applyStimulus(4'b0100, 32'h00A5_0000, 1'b0);
        tick();
        checkOutput("sw_gnt", {28'b0, gnt}, 32'h4);
        checkOutput("sw_lat_i", {24'b0, latI}, 32'hA5);
        checkOutput("sw_ge_k", {31'b0, latGe}, 32'd0);
        checkOutput("sw_busy", {31'b0, busy}, 32'd1);
        applyStimulus(4'b0000, 32'h0, 1'b0);
        tick();
        checkOutput("sw_ge_k1", {31'b0, latGe}, 32'd1);
        tick();
        checkOutput("sw_ge_k2", {31'b0, latGe}, 32'd1);
        tick();
        checkOutput("sw_ge_k3", {31'b0, latGe}, 32'd0);
        checkOutput("sw_done_k3", {31'b0, done}, 32'd0);
        tick();
        checkOutput("sw_done_k4", {31'b0, done}, 32'd1);
        checkOutput("sw_gnt_k4", {28'b0, gnt}, 32'h4);
        tick();
        checkOutput("sw_done_k5", {31'b0, done}, 32'd0);
        checkOutput("sw_gnt_k5", {28'b0, gnt}, 32'd0);
        checkOutput("sw_busy_k5", {31'b0, busy}, 32'd0);

        // data capture: requester 3 next after pointer 2
        applyStimulus(4'b1000, 32'h3C00_0000, 1'b0);
        tick();
        checkOutput("dc_gnt", {28'b0, gnt}, 32'h8);
        checkOutput("dc_lat_i", {24'b0, latI}, 32'h3C);
        applyStimulus(4'b0000, 32'h3C00_0000, 1'b0);
        tick();
        checkOutput("dc_ge_k1", {31'b0, latGe}, 32'd1);
        applyStimulus(4'b0000, 32'hFF00_0000, 1'b0);
        tick();
        checkOutput("dc_lat_i_open", {24'b0, latI}, 32'h3C);
        tick();
        tick();
        checkOutput("dc_done", {31'b0, done}, 32'd1);
        checkOutput("dc_lat_i_fin", {24'b0, latI}, 32'h3C);
        tick();
        checkOutput("dc_lat_i_idle", {24'b0, latI}, 32'h3C);
        checkOutput("dc_busy_idle", {31'b0, busy}, 32'd0);

        // fairness: pointer is 3, so grants run 0,1,2,3,0 at edges 1,7,13,19,25
        doneCount = 0;
        applyStimulus(4'b1111, 32'h4433_2211, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (done === 1'b1) doneCount++;
            if ((c - 1) % 6 == 0)
                checkOutput($sformatf("fair_gnt_%0d", c), {28'b0, gnt}, 32'd1 << (((c - 1) / 6) % 4));
            checkOutput($sformatf("fair_ge_%0d", c), {31'b0, latGe},
                        {31'b0, ((c - 1) % 6 == 1) || ((c - 1) % 6 == 2)});
            checkOutput($sformatf("fair_done_%0d", c), {31'b0, done}, {31'b0, (c - 1) % 6 == 4});
            checkOutput($sformatf("fair_ge_vs_init_%0d", c), {31'b0, latGe & (latRst | latSet)}, 32'd0);
            if (c == 25) applyStimulus(4'b0000, 32'h4433_2211, 1'b0);
        end
        checkOutput("fair_done_count", doneCount, 32'd5);

        // soft init wins over a simultaneous request, then requester 0 is granted
        applyStimulus(4'b0001, 32'h0000_0077, 1'b1);
        tick();
        checkOutput("si_lat_rst_e", {31'b0, latRst}, 32'd1);
        checkOutput("si_busy_e", {31'b0, busy}, 32'd1);
        checkOutput("si_gnt_e", {28'b0, gnt}, 32'd0);
        applyStimulus(4'b0001, 32'h0000_0077, 1'b0);
        tick();
        checkOutput("si_lat_rst_e1", {31'b0, latRst}, 32'd1);
        checkOutput("si_gnt_e1", {28'b0, gnt}, 32'd0);
        tick();
        checkOutput("si_lat_rst_e2", {31'b0, latRst}, 32'd0);
        checkOutput("si_busy_e2", {31'b0, busy}, 32'd0);
        tick();
        checkOutput("si_gnt", {28'b0, gnt}, 32'h1);
        checkOutput("si_lat_i", {24'b0, latI}, 32'h77);
        applyStimulus(4'b0000, 32'h0, 1'b1);
        tick();
        checkOutput("si_ignored_rst", {31'b0, latRst}, 32'd0);
        checkOutput("si_ignored_ge", {31'b0, latGe}, 32'd1);
        applyStimulus(4'b0000, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("si_done", {31'b0, done}, 32'd1);
        tick();
        checkOutput("si_busy_end", {31'b0, busy}, 32'd0);

        // async reset during OPEN
        applyStimulus(4'b0010, 32'h0000_5A00, 1'b0);
        tick();
        checkOutput("ar_gnt", {28'b0, gnt}, 32'h2);
        applyStimulus(4'b0000, 32'h0, 1'b0);
        tick();
        checkOutput("ar_ge_open", {31'b0, latGe}, 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("ar_ge", {31'b0, latGe}, 32'd0);
        checkOutput("ar_gnt_clear", {28'b0, gnt}, 32'd0);
        checkOutput("ar_lat_rst", {31'b0, latRst}, 32'd1);
        checkOutput("ar_busy", {31'b0, busy}, 32'd1);
        checkOutput("ar_lat_i", {24'b0, latI}, 32'd0);
        tick();
        checkOutput("ar_no_done1", {31'b0, done}, 32'd0);
        tick();
        checkOutput("ar_no_done2", {31'b0, done}, 32'd0);
        rstN = 1'b1;
        tick();
        checkOutput("ar_init1_rst", {31'b0, latRst}, 32'd1);
        checkOutput("ar_init1_done", {31'b0, done}, 32'd0);
        tick();
        checkOutput("ar_init2_rst", {31'b0, latRst}, 32'd0);
        checkOutput("ar_init2_busy", {31'b0, busy}, 32'd0);

        // pointer restored by reset: requester 0 wins first
        applyStimulus(4'b1111, 32'h0, 1'b0);
        tick();
        checkOutput("ar_ptr_gnt", {28'b0, gnt}, 32'h1);
        applyStimulus(4'b0000, 32'h0, 1'b0);
        repeat (6) tick();
        checkOutput("end_busy", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
